move_search_ctrl: RTL and testbench

Root-search sequencer between the UCI command handler and the move generator / move evaluator pair. On a `go` it loads the current board into the move generator and pulls the legal-move stream one move at a time. It sends each move to the evaluator and keeps the highest-scoring one. When the list ends, on `stop`, or on timeout, it reports the best move back to the UCI handler with a valid/ready handshake.

---
 rtl/move_search_ctrl_if.sv | 53 +++++
 rtl/move_search_ctrl.sv | 136 +++++++++++++
 tb/tb_move_search_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_search_ctrl_if.sv
// Handshake bundle between the root-search sequencer and the UCI handler,
// move generator and move evaluator. slave = sequencer side, master = environment side.
interface move_search_ctrl_if #(
  parameter int TIMER_W = 32,
  parameter int CNT_W   = 8,
  parameter int SCORE_W = 16,
  parameter int BOARD_W = 64,
  parameter int MOVE_W  = 16
);
  // UCI command side
  logic                      go_in;
  logic [BOARD_W-1:0]        board_in;
  logic [TIMER_W-1:0]        movetime_in;
  logic                      stop_in;
  // move generator side
  logic [BOARD_W-1:0]        mg_board_out;
  logic                      mg_valid_out;
  logic                      mg_ready_in;
  logic [MOVE_W-1:0]         mg_move_in;
  logic                      mg_move_valid_in;
  logic                      mg_move_ready_out;
  logic                      mg_done_in;
  // evaluator side
  logic [MOVE_W-1:0]         ev_move_out;
  logic                      ev_valid_out;
  logic signed [SCORE_W-1:0] ev_score_in;
  logic                      ev_score_valid_in;
  // report back to UCI
  logic [MOVE_W-1:0]         best_move_out;
  logic                      best_none_out;
  logic [CNT_W-1:0]          nodes_out;
  logic                      best_valid_out;
  logic                      best_ready_in;
  logic                      busy_out;

  modport slave (
    input  go_in, board_in, movetime_in, stop_in,
    input  mg_ready_in, mg_move_in, mg_move_valid_in, mg_done_in,
    input  ev_score_in, ev_score_valid_in, best_ready_in,
    output mg_board_out, mg_valid_out, mg_move_ready_out,
    output ev_move_out, ev_valid_out,
    output best_move_out, best_none_out, nodes_out, best_valid_out, busy_out
  );

  modport master (
    output go_in, board_in, movetime_in, stop_in,
    output mg_ready_in, mg_move_in, mg_move_valid_in, mg_done_in,
    output ev_score_in, ev_score_valid_in, best_ready_in,
    input  mg_board_out, mg_valid_out, mg_move_ready_out,
    input  ev_move_out, ev_valid_out,
    input  best_move_out, best_none_out, nodes_out, best_valid_out, busy_out
  );
endinterface

// File: rtl/move_search_ctrl.sv
// Root-search sequencer: streams legal moves from the generator through the
// evaluator, keeps the best-scoring move and reports it on finish, stop or timeout.
module move_search_ctrl #(
  parameter int TIMER_W = 32,
  parameter int CNT_W   = 8,
  parameter int SCORE_W = 16,
  parameter int BOARD_W = 64,
  parameter int MOVE_W  = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  move_search_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, PULL, EVAL, REPORT} state_e;

  state_e                    state_q, state_d;
  logic [BOARD_W-1:0]        board_q, board_d;
  logic [TIMER_W-1:0]        timer_q, timer_d;
  logic [CNT_W-1:0]          nodes_q, nodes_d;
  logic [MOVE_W-1:0]         move_q, move_d;
  logic [MOVE_W-1:0]         best_move_q, best_move_d;
  logic signed [SCORE_W-1:0] best_score_q, best_score_d;
  logic                      have_best_q, have_best_d;
  logic                      pend_q, pend_d;
  logic                      ev_valid_q, ev_valid_d;

  logic active, expire, abort, xfer, score_hit, better;

  assign active    = (state_q == LOAD) || (state_q == PULL) || (state_q == EVAL);
  assign expire    = active && (timer_q == TIMER_W'(1));
  // abort sees a stop/expiry in the same cycle so the report follows one cycle later
  assign abort     = pend_q || (active && (bus.stop_in || expire));
  assign xfer      = (state_q == PULL) && bus.mg_move_valid_in;
  assign score_hit = (state_q == EVAL) && bus.ev_score_valid_in;
  assign better    = !have_best_q || ($signed(bus.ev_score_in) > best_score_q);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.go_in) state_d = LOAD;
      LOAD:    if (abort) state_d = REPORT;
               else if (bus.mg_ready_in) state_d = PULL;
      // a move transfer wins over a coincident stop; the stop stays pending
      PULL:    if (xfer) state_d = EVAL;
               else if (bus.mg_done_in || abort) state_d = REPORT;
      EVAL:    if (bus.ev_score_valid_in) state_d = abort ? REPORT : PULL;
      REPORT:  if (bus.best_ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mg_valid_out      = (state_q == LOAD) && !abort && bus.mg_ready_in;
    bus.mg_board_out      = board_q;
    bus.mg_move_ready_out = (state_q == PULL);
    bus.ev_move_out       = move_q;
    bus.ev_valid_out      = ev_valid_q;
    bus.best_valid_out    = (state_q == REPORT);
    bus.best_none_out     = (state_q == REPORT) && !have_best_q;
    bus.best_move_out     = ((state_q == REPORT) && have_best_q) ? best_move_q : '0;
    bus.nodes_out         = nodes_q;
    bus.busy_out          = (state_q != IDLE);
  end

  always_comb begin
    board_d      = board_q;
    timer_d      = timer_q;
    nodes_d      = nodes_q;
    move_d       = move_q;
    best_move_d  = best_move_q;
    best_score_d = best_score_q;
    have_best_d  = have_best_q;
    pend_d       = pend_q;
    ev_valid_d   = 1'b0;

    // a zero budget loads a zero count, which never decrements and never expires
    if (active && (timer_q != '0)) timer_d = timer_q - TIMER_W'(1);
    if (active && (bus.stop_in || expire)) pend_d = 1'b1;

    if (state_q == IDLE) begin
      pend_d = 1'b0;
      if (bus.go_in) begin
        board_d      = bus.board_in;
        timer_d      = bus.movetime_in;
        nodes_d      = '0;
        have_best_d  = 1'b0;
        best_move_d  = '0;
        best_score_d = '0;
      end
    end
    if ((state_q == REPORT) && bus.best_ready_in) pend_d = 1'b0;

    if (xfer) begin
      move_d     = bus.mg_move_in;
      ev_valid_d = 1'b1;
    end

    if (score_hit) begin
      if (nodes_q != '1) nodes_d = nodes_q + CNT_W'(1);
      if (better) begin
        best_move_d  = move_q;
        best_score_d = bus.ev_score_in;
      end
      have_best_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      board_q      <= '0;
      timer_q      <= '0;
      nodes_q      <= '0;
      move_q       <= '0;
      best_move_q  <= '0;
      best_score_q <= '0;
      have_best_q  <= 1'b0;
      pend_q       <= 1'b0;
      ev_valid_q   <= 1'b0;
    end else begin
      board_q      <= board_d;
      timer_q      <= timer_d;
      nodes_q      <= nodes_d;
      move_q       <= move_d;
      best_move_q  <= best_move_d;
      best_score_q <= best_score_d;
      have_best_q  <= have_best_d;
      pend_q       <= pend_d;
      ev_valid_q   <= ev_valid_d;
    end
  end
endmodule

// File: tb/tb_move_search_ctrl.sv
// Self-checking bench: behavioural generator/evaluator models drive the sequencer,
// and a reference picks the first highest-scoring move among those actually scored.
module tb_move_search_ctrl;
  localparam int TIMER_W = 32;
  localparam int CNT_W   = 8;
  localparam int SCORE_W = 16;
  localparam int BOARD_W = 64;
  localparam int MOVE_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  move_search_ctrl_if #(.TIMER_W(TIMER_W), .CNT_W(CNT_W), .SCORE_W(SCORE_W),
                        .BOARD_W(BOARD_W), .MOVE_W(MOVE_W)) bus();

  move_search_ctrl #(.TIMER_W(TIMER_W), .CNT_W(CNT_W), .SCORE_W(SCORE_W),
                     .BOARD_W(BOARD_W), .MOVE_W(MOVE_W)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0]        gen_list[$];
  logic [15:0]        gen_q[$];
  logic [15:0]        scored_q[$];
  logic signed [15:0] score_tab [logic [15:0]];
  logic [15:0]        ev_mv;
  logic [63:0]        board_seen;
  logic [63:0]        last_board;
  int  gen_gap = 1, ev_lat = 1;
  bit  gen_run = 0, ev_pending = 0;
  int  gen_next = 0, ev_due = 0, last_score_cyc = 0, done_cyc = 0, mg_start_cyc = 0, xfers = 0;

  // environment: move generator and evaluator models, one step per cycle
  initial begin
    bus.ev_score_in = '0; bus.ev_score_valid_in = 1'b0;
    bus.mg_move_in = '0;  bus.mg_move_valid_in = 1'b0;
    bus.mg_done_in = 1'b0; bus.mg_ready_in = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      bus.ev_score_valid_in = 1'b0;
      bus.mg_done_in = 1'b0;
      bus.mg_move_valid_in = 1'b0;
      if (ev_pending && cyc >= ev_due) begin
        bus.ev_score_valid_in = 1'b1;
        bus.ev_score_in = score_tab[ev_mv];
        ev_pending = 0;
        scored_q.push_back(ev_mv);
        last_score_cyc = cyc;
      end
      if (gen_run && gen_q.size() > 0 && cyc >= gen_next) begin
        bus.mg_move_valid_in = 1'b1;
        bus.mg_move_in = gen_q[0];
      end
      #1;
      if (gen_run && gen_q.size() == 0 && cyc >= gen_next && bus.mg_move_ready_out) begin
        bus.mg_done_in = 1'b1;
        gen_run = 0;
        done_cyc = cyc;
      end
      if (bus.mg_valid_out && bus.mg_ready_in) begin
        gen_run = 1; gen_q = gen_list; gen_next = cyc + gen_gap;
        mg_start_cyc = cyc; board_seen = bus.mg_board_out;
      end
      if (bus.mg_move_valid_in && bus.mg_move_ready_out) begin
        void'(gen_q.pop_front());
        gen_next = cyc + gen_gap;
        xfers++;
      end
      if (bus.ev_valid_out) begin
        ev_pending = 1; ev_mv = bus.ev_move_out; ev_due = cyc + ev_lat;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_env();
    gen_list.delete(); gen_q.delete(); scored_q.delete(); score_tab.delete();
    gen_run = 0; ev_pending = 0; xfers = 0;
  endtask

  task automatic add_move(input logic [15:0] m, input int s);
    gen_list.push_back(m);
    score_tab[m] = 16'(s);
  endtask

  // reference: first move holding the maximum score over everything scored
  function automatic void model(output logic [15:0] bm, output logic none, output logic [7:0] nodes);
    int mx;
    bm = '0;
    none = (scored_q.size() == 0);
    mx = -100000;
    foreach (scored_q[i]) if (int'(score_tab[scored_q[i]]) > mx) mx = int'(score_tab[scored_q[i]]);
    for (int i = 0; i < scored_q.size(); i++) begin
      if (int'(score_tab[scored_q[i]]) == mx) begin
        bm = scored_q[i];
        break;
      end
    end
    nodes = (scored_q.size() > 255) ? 8'd255 : 8'(scored_q.size());
  endfunction

  task automatic do_go(input logic [31:0] mt, output int gcyc);
    tick();
    last_board = {$urandom, $urandom};
    bus.board_in = last_board;
    bus.movetime_in = mt;
    bus.go_in = 1'b1;
    gcyc = cyc;
    tick();
    bus.go_in = 1'b0;
    bus.board_in = ~last_board;
    bus.movetime_in = '0;
  endtask

  task automatic wait_report(output int rc);
    bit found = 0;
    rc = -1;
    for (int i = 0; i < 3000 && !found; i++) begin
      tick();
      if (bus.best_valid_out) begin
        found = 1;
        rc = cyc;
      end
    end
    if (!found) begin
      errors++; checks++;
      $display("FAIL report_timeout: best_valid_out never rose within 3000 cycles");
    end else begin
      $display("report cyc=%0d move=%04h none=%0b nodes=%0d", rc, bus.best_move_out,
               bus.best_none_out, bus.nodes_out);
    end
  endtask

  task automatic accept();
    bus.best_ready_in = 1'b1;
    tick();
    bus.best_ready_in = 1'b0;
  endtask

  task automatic wait_ev(output int e);
    e = -1;
    for (int i = 0; i < 500 && e < 0; i++) begin
      tick();
      if (bus.ev_valid_out) e = cyc;
    end
    if (e < 0) begin
      errors++; checks++;
      $display("FAIL ev_timeout: ev_valid_out never rose");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.go_in = 1'b0; bus.stop_in = 1'b0; bus.best_ready_in = 1'b0;
    bus.board_in = '0; bus.movetime_in = '0;
    repeat (3) tick();
    checks++;
    if ({bus.busy_out, bus.best_valid_out, bus.mg_valid_out, bus.ev_valid_out,
         bus.mg_move_ready_out, bus.best_none_out} !== 6'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b required 000000", {bus.busy_out,
        bus.best_valid_out, bus.mg_valid_out, bus.ev_valid_out, bus.mg_move_ready_out, bus.best_none_out}); end
    checks++;
    if (bus.nodes_out !== 8'd0 || bus.best_move_out !== 16'd0 || bus.mg_board_out !== 64'd0)
      begin errors++; $display("FAIL reset_data: nodes=%0d move=%h board=%h required zeros",
        bus.nodes_out, bus.best_move_out, bus.mg_board_out); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_three_moves();
    int g, rc;
    logic [15:0] bm; logic none; logic [7:0] nd;
    clear_env(); gen_gap = 1; ev_lat = 3;
    add_move(16'h0A11, 10); add_move(16'h0B22, 40); add_move(16'h0C33, 40);
    do_go(32'd0, g);
    wait_report(rc);
    model(bm, none, nd);
    checks++;
    if (mg_start_cyc !== g + 1) begin errors++; $display("FAIL go_latency: mg_valid at %0d required %0d", mg_start_cyc, g + 1); end
    checks++;
    if (board_seen !== last_board) begin errors++; $display("FAIL mg_board: got %h required %h", board_seen, last_board); end
    checks++;
    if (bus.best_move_out !== bm || bm !== 16'h0B22) begin errors++; $display("FAIL three_best: got %h required %h", bus.best_move_out, bm); end
    checks++;
    if (bus.nodes_out !== nd || bus.best_none_out !== none) begin errors++; $display("FAIL three_nodes: got %0d/%0b required %0d/%0b", bus.nodes_out, bus.best_none_out, nd, none); end
    checks++;
    if (rc !== done_cyc + 1) begin errors++; $display("FAIL done_latency: report at %0d required %0d", rc, done_cyc + 1); end
    accept();
    checks++;
    if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL three_idle: busy=%0b required 0", bus.busy_out); end
  endtask

  task automatic test_no_moves();
    int g, rc;
    clear_env(); gen_gap = 1; ev_lat = 1;
    do_go(32'd0, g);
    wait_report(rc);
    checks++;
    if (bus.best_none_out !== 1'b1 || bus.best_move_out !== 16'd0 || bus.nodes_out !== 8'd0)
      begin errors++; $display("FAIL no_moves: none=%0b move=%h nodes=%0d required 1/0/0",
        bus.best_none_out, bus.best_move_out, bus.nodes_out); end
    accept();
  endtask

  task automatic test_timeout();
    int g, rc, exp_rc;
    logic [15:0] bm; logic none; logic [7:0] nd;
    clear_env(); gen_gap = 8; ev_lat = int'($urandom_range(2, 4));
    for (int i = 0; i < 6; i++) add_move({8'(i + 1), 8'($urandom)}, int'($urandom_range(0, 60)) - 30);
    do_go(32'd20, g);
    wait_report(rc);
    model(bm, none, nd);
    exp_rc = (last_score_cyc + 1 > g + 21) ? last_score_cyc + 1 : g + 21;
    checks++;
    if (rc !== exp_rc) begin errors++; $display("FAIL timeout_latency: report at %0d required %0d", rc, exp_rc); end
    checks++;
    if (bus.best_move_out !== bm || bus.nodes_out !== nd || bus.best_none_out !== none)
      begin errors++; $display("FAIL timeout_best: got %h/%0d required %h/%0d", bus.best_move_out, bus.nodes_out, bm, nd); end
    checks++;
    if (xfers !== scored_q.size() || ev_pending) begin errors++; $display("FAIL timeout_inflight: xfers=%0d scored=%0d", xfers, scored_q.size()); end
    accept();
  endtask

  task automatic test_stop_eval();
    int g, e, rc;
    logic [15:0] bm; logic none; logic [7:0] nd;
    clear_env(); gen_gap = 1; ev_lat = 3;
    add_move(16'h1234, -5); add_move(16'h2345, 100); add_move(16'h3456, 90);
    do_go(32'd0, g);
    wait_ev(e);
    tick(); bus.stop_in = 1'b1;
    tick(); bus.stop_in = 1'b0;
    wait_report(rc);
    model(bm, none, nd);
    checks++;
    if (rc !== e + 4) begin errors++; $display("FAIL stop_latency: report at %0d required %0d", rc, e + 4); end
    checks++;
    if (bus.best_move_out !== bm || bm !== 16'h1234 || bus.nodes_out !== nd || nd !== 8'd1)
      begin errors++; $display("FAIL stop_best: got %h/%0d required %h/%0d", bus.best_move_out, bus.nodes_out, bm, nd); end
    checks++;
    if (bus.best_none_out !== 1'b0) begin errors++; $display("FAIL stop_none: got %0b required 0", bus.best_none_out); end
    accept();
  endtask

  task automatic test_report_hold();
    int g, rc;
    logic [15:0] bm; logic none; logic [7:0] nd;
    clear_env(); gen_gap = 1; ev_lat = 1;
    add_move(16'h4001, 3); add_move(16'h5002, 8);
    do_go(32'd0, g);
    wait_report(rc);
    model(bm, none, nd);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) bus.go_in = 1'b1;
      tick();
      bus.go_in = 1'b0;
      checks++;
      if ({bus.best_valid_out, bus.best_none_out, bus.best_move_out, bus.nodes_out} !== {1'b1, none, bm, nd})
        begin errors++; $display("FAIL hold_%0d: got %b/%h/%0d required 1/%h/%0d", i, bus.best_valid_out,
          bus.best_move_out, bus.nodes_out, bm, nd); end
    end
    accept();
    checks++;
    if (bus.busy_out !== 1'b0 || bus.best_valid_out !== 1'b0) begin errors++; $display("FAIL hold_accept: busy=%0b valid=%0b required 0/0", bus.busy_out, bus.best_valid_out); end
    repeat (3) tick();
    checks++;
    if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL go_in_report: busy=%0b required 0", bus.busy_out); end
  endtask

  task automatic test_reset_mid();
    int g, e, rc;
    logic [15:0] bm; logic none; logic [7:0] nd;
    clear_env(); gen_gap = 1; ev_lat = 10;
    add_move(16'h6001, 1); add_move(16'h6002, 2); add_move(16'h6003, 3);
    do_go(32'd0, g);
    wait_ev(e);
    tick();
    #1 rst_n = 1'b0;
    clear_env();
    #1;
    checks++;
    if ({bus.busy_out, bus.ev_valid_out, bus.mg_move_ready_out, bus.best_valid_out, bus.mg_valid_out} !== 5'b0 ||
        bus.nodes_out !== 8'd0 || bus.mg_board_out !== 64'd0)
      begin errors++; $display("FAIL async_reset: busy=%0b nodes=%0d board=%h required zeros",
        bus.busy_out, bus.nodes_out, bus.mg_board_out); end
    tick();
    rst_n = 1'b1;
    gen_gap = 2; ev_lat = 2;
    add_move(16'h7001, -7); add_move(16'h7002, 12);
    do_go(32'd0, g);
    wait_report(rc);
    model(bm, none, nd);
    checks++;
    if (bus.best_move_out !== bm || bus.nodes_out !== nd || nd !== 8'd2)
      begin errors++; $display("FAIL after_reset: got %h/%0d required %h/%0d", bus.best_move_out, bus.nodes_out, bm, nd); end
    accept();
  endtask

  task automatic test_back_to_back();
    int g, rc, n;
    logic [15:0] bm; logic none; logic [7:0] nd;
    for (int it = 0; it < 6; it++) begin
      clear_env();
      gen_gap = int'($urandom_range(1, 3));
      ev_lat = int'($urandom_range(1, 4));
      n = int'($urandom_range(0, 6));
      for (int i = 0; i < n; i++) add_move({8'(i + 1), 8'($urandom)}, int'($urandom_range(0, 20)) - 10);
      do_go(32'd0, g);
      wait_report(rc);
      model(bm, none, nd);
      checks++;
      if (bus.best_move_out !== bm || bus.nodes_out !== nd || bus.best_none_out !== none)
        begin errors++; $display("FAIL b2b_%0d: got %h/%0d/%0b required %h/%0d/%0b", it, bus.best_move_out,
          bus.nodes_out, bus.best_none_out, bm, nd, none); end
      accept();
    end
  endtask

  task automatic test_saturate();
    int g, rc;
    logic [15:0] bm; logic none; logic [7:0] nd;
    clear_env(); gen_gap = 1; ev_lat = 1;
    for (int i = 0; i < 260; i++) add_move(16'(i + 16'h1000), 7);
    do_go(32'd0, g);
    wait_report(rc);
    model(bm, none, nd);
    checks++;
    if (bus.nodes_out !== nd || nd !== 8'd255) begin errors++; $display("FAIL saturate: nodes=%0d required %0d", bus.nodes_out, nd); end
    checks++;
    if (bus.best_move_out !== bm || bm !== 16'h1000) begin errors++; $display("FAIL tie_first: got %h required %h", bus.best_move_out, bm); end
    accept();
  endtask

  initial begin
    test_reset();
    test_three_moves();
    test_no_moves();
    test_timeout();
    test_stop_eval();
    test_report_hold();
    test_reset_mid();
    test_back_to_back();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
